// File: rtl/qlearn_pkg.sv
// rtl/qlearn_pkg.sv - shared types and constants for the Q-learning agent
package qlearn_pkg;

    localparam int NUM_STATES_DEF  = 64;
    localparam int NUM_ACTIONS_DEF = 4;
    localparam int Q_W_DEF         = 16;
    localparam int ALPHA_SH_DEF    = 2;
    localparam int GAMMA_SH_DEF    = 2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_SCAN_CUR,
        ST_ACT,
        ST_WAIT_OBS,
        ST_SCAN_NXT,
        ST_UPDATE
    } agent_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/q_table_ram.sv
// rtl/q_table_ram.sv - single-port synchronous-read Q-value table
module q_table_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic signed [DW-1:0] wdata,
    output logic signed [DW-1:0] rdata
);

    logic signed [DW-1:0] mem [DEPTH];

    // Gated by en so a frozen agent also freezes the read register
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/q_agent_core.sv
// rtl/q_agent_core.sv - tabular Q-learning agent with epsilon-greedy action choice
module q_agent_core
    import qlearn_pkg::*;
#(
    parameter int NUM_STATES  = NUM_STATES_DEF,
    parameter int NUM_ACTIONS = NUM_ACTIONS_DEF,
    parameter int Q_W         = Q_W_DEF,
    parameter int ALPHA_SH    = ALPHA_SH_DEF,
    parameter int GAMMA_SH    = GAMMA_SH_DEF,
    localparam int S_W        = $clog2(NUM_STATES),
    localparam int A_W        = $clog2(NUM_ACTIONS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [S_W-1:0]        start_state,
    input  logic [15:0]           epsilon,
    output logic [A_W-1:0]        action,
    output logic                  action_valid,
    input  logic                  action_ready,
    input  logic                  obs_valid,
    output logic                  obs_ready,
    input  logic signed [Q_W-1:0] obs_reward,
    input  logic [S_W-1:0]        obs_state,
    input  logic                  obs_terminal,
    output logic                  busy,
    output logic [15:0]           step_count
);

    localparam int AW    = S_W + A_W;
    localparam int DEPTH = NUM_STATES * NUM_ACTIONS;
    localparam int QX    = Q_W + 2;
    localparam logic [AW-1:0]  CLR_END  = AW'(DEPTH - 1);
    localparam logic [A_W:0]   SCAN_END = (A_W + 1)'(NUM_ACTIONS);
    localparam logic signed [Q_W-1:0] Q_MAX = {1'b0, {(Q_W-1){1'b1}}};
    localparam logic signed [Q_W-1:0] Q_MIN = {1'b1, {(Q_W-1){1'b0}}};

    agent_state_t state, state_nxt;

    logic [15:0]           lfsr;
    logic [AW-1:0]         clr_addr;
    logic [A_W:0]          scan_idx;
    logic [S_W-1:0]        cur_state;
    logic [S_W-1:0]        nxt_state;
    logic signed [Q_W-1:0] reward;
    logic signed [Q_W-1:0] q_sa;
    logic signed [Q_W-1:0] max_q;
    logic [A_W-1:0]        max_a;
    logic                  terminal;

    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic signed [Q_W-1:0] ram_wdata;
    logic signed [Q_W-1:0] ram_rdata;

    logic                  scan_last;
    logic                  explore;
    logic signed [Q_W-1:0] best_q;
    logic [A_W-1:0]        best_a;
    logic signed [QX-1:0]  target;
    logic signed [QX-1:0]  q_new;
    logic signed [Q_W-1:0] q_sat;

    assign busy         = (state == ST_CLEAR);
    assign action_valid = (state == ST_ACT);
    assign obs_ready    = (state == ST_WAIT_OBS);
    assign scan_last    = (scan_idx == SCAN_END);
    assign explore      = (lfsr < epsilon);

    // Read data lags the address by a cycle, so index k compares entry k-1
    always_comb begin
        best_q = max_q;
        best_a = max_a;
        if (scan_idx == (A_W + 1)'(1) || ram_rdata > max_q) begin
            best_q = ram_rdata;
            best_a = scan_idx[A_W-1:0] - A_W'(1);
        end
    end

    always_comb begin
        target = QX'(reward);
        if (!terminal) begin
            target = QX'(reward) + (QX'(max_q) - (QX'(max_q) >>> GAMMA_SH));
        end
        q_new = QX'(q_sa) + ((target - QX'(q_sa)) >>> ALPHA_SH);
        if (q_new[QX-1:Q_W-1] == '0 || q_new[QX-1:Q_W-1] == '1) begin
            q_sat = q_new[Q_W-1:0];
        end else begin
            q_sat = q_new[QX-1] ? Q_MIN : Q_MAX;
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = '0;
        ram_addr  = {cur_state, action};
        case (state)
            ST_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = clr_addr;
            end
            ST_SCAN_CUR: ram_addr = {cur_state, scan_idx[A_W-1:0]};
            ST_SCAN_NXT: ram_addr = {nxt_state, scan_idx[A_W-1:0]};
            ST_UPDATE: begin
                ram_we    = 1'b1;
                ram_wdata = q_sat;
            end
            default: ram_addr = {cur_state, action};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR:    if (clr_addr == CLR_END) state_nxt = ST_SCAN_CUR;
            ST_SCAN_CUR: if (scan_last) state_nxt = ST_ACT;
            ST_ACT:      if (action_ready) state_nxt = ST_WAIT_OBS;
            ST_WAIT_OBS: if (obs_valid) state_nxt = obs_terminal ? ST_UPDATE : ST_SCAN_NXT;
            ST_SCAN_NXT: if (scan_last) state_nxt = ST_UPDATE;
            ST_UPDATE:   state_nxt = terminal ? ST_SCAN_CUR : ST_ACT;
            default:     state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            lfsr       <= LFSR_SEED;
            clr_addr   <= '0;
            scan_idx   <= '0;
            cur_state  <= '0;
            nxt_state  <= '0;
            reward     <= '0;
            q_sa       <= '0;
            max_q      <= '0;
            max_a      <= '0;
            terminal   <= 1'b0;
            action     <= '0;
            step_count <= '0;
        end else if (en) begin
            state <= state_nxt;
            lfsr  <= lfsr_next(lfsr);
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + AW'(1);
                    if (clr_addr == CLR_END) cur_state <= start_state;
                end
                ST_SCAN_CUR, ST_SCAN_NXT: begin
                    scan_idx <= scan_last ? '0 : scan_idx + (A_W + 1)'(1);
                    if (scan_idx != '0) begin
                        max_q <= best_q;
                        max_a <= best_a;
                    end
                    if (scan_last && state == ST_SCAN_CUR) begin
                        action <= explore ? lfsr[A_W-1:0] : best_a;
                    end
                end
                ST_WAIT_OBS: begin
                    // Read port has been parked on (cur_state, action) since ACT
                    if (obs_valid) begin
                        reward    <= obs_reward;
                        nxt_state <= obs_state;
                        terminal  <= obs_terminal;
                        q_sa      <= ram_rdata;
                    end
                end
                ST_UPDATE: begin
                    step_count <= step_count + 16'd1;
                    if (terminal) begin
                        cur_state <= start_state;
                    end else begin
                        cur_state <= nxt_state;
                        action    <= explore ? lfsr[A_W-1:0] : max_a;
                    end
                end
                default: ;
            endcase
        end
    end

    q_table_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (Q_W)
    ) u_ram (
        .clk   (clk),
        .en    (en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/q_agent_core.md
Q_AGENT_CORE -- requirements
Module: q_agent_core

Interface
REQ-001 Parameter NUM_STATES, default 64, number of environment states; SHALL be a power of two.
REQ-002 Parameter NUM_ACTIONS, default 4, actions per state; SHALL be a power of two, at least 2.
REQ-003 Parameter Q_W, default 16, signed Q-value and reward width.
REQ-004 Parameter ALPHA_SH, default 2, learning rate 2^-ALPHA_SH.
REQ-005 Parameter GAMMA_SH, default 2, discount 1-2^-GAMMA_SH.
REQ-006 Derived widths: S_W=$clog2(NUM_STATES), A_W=$clog2(NUM_ACTIONS).
REQ-007 clk  in  1  single clock; all state is on the rising edge.
REQ-008 rst_n  in  1  reset is asynchronous and active-low.
REQ-009 en  in  1  advance enable; low freezes the FSM, LFSR and all outputs.
REQ-010 start_state  in  S_W  initial state after clear and after a terminal observation.
REQ-011 epsilon  in  16  exploration threshold; explore when lfsr < epsilon.
REQ-012 action  out  A_W  chosen action.
REQ-013 action_valid / action_ready  out/in  1  action handshake.
REQ-014 obs_valid / obs_ready  in/out  1  observation handshake.
REQ-015 obs_reward  in  Q_W signed  reward; obs_state  in  S_W  next state; obs_terminal  in  1  episode end.
REQ-016 busy  out  1  high during table clear; step_count  out  16  completed updates, wraps.

Function
REQ-017 FSM states: CLEAR, SCAN_CUR, ACT, WAIT_OBS, SCAN_NXT, UPDATE.
REQ-018 CLEAR: write 0 to one entry per cycle, NUM_STATES*NUM_ACTIONS cycles; busy=1; cur_state<=start_state. Then go to SCAN_CUR.
REQ-019 SCAN_CUR/SCAN_NXT: read Q(s,0..NUM_ACTIONS-1) with 1-cycle sync read.
  - Takes NUM_ACTIONS+1 cycles.
  - Tracks max and argmax with strict greater-than, so ties go to the lowest index.
REQ-020 ACT is entered with greedy = argmax(cur_state).
  - On entry, sample the LFSR: if lfsr[15:0] < epsilon, action = lfsr[A_W-1:0]; else action = greedy.
  - action_valid=1, action held stable until action_ready; the transfer moves the FSM to WAIT_OBS.
REQ-021 WAIT_OBS: obs_ready=1; obs_ready is 0 in every other state.
  - The obs_valid&&obs_ready transfer latches reward, next state and terminal flag.
  - Next state is SCAN_NXT if non-terminal, else UPDATE.
REQ-022 UPDATE, single cycle:
  - target = r + (maxQ' - (maxQ' >>> GAMMA_SH)), or target = r if terminal.
  - Q(s,a) <= Q(s,a) + ((target - Q(s,a)) >>> ALPHA_SH).
  - Intermediates use Q_W+2 bits; the written result saturates to [-2^(Q_W-1), 2^(Q_W-1)-1].
REQ-023 After UPDATE: step_count += 1.
  - Non-terminal: cur_state <= obs_state, greedy reuses the SCAN_NXT argmax, go to ACT.
  - Terminal: cur_state <= start_state, go to SCAN_CUR.
REQ-024 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1; steps every cycle en=1.
REQ-025 When en=0 nothing changes, including an in-progress handshake; obs and action transfers only occur when en=1.
REQ-026 A self-loop where obs_state == cur_state is legal; SCAN_NXT reads pre-update values.

Reset
REQ-027 On rst_n low:
  - FSM=CLEAR, action=0, action_valid=0, obs_ready=0, busy=1, step_count=0, lfsr=16'hACE1.
REQ-028 Reset mid-operation abandons any handshake, and the table is fully re-cleared.

Structure
REQ-029 Package qlearn_pkg SHALL hold the FSM state enum, default parameter values and the LFSR seed/taps constants.
REQ-030 Sub-module q_table_ram SHALL be a single-port, sync-read, NUM_STATES*NUM_ACTIONS x Q_W memory addressed {state,action}.

Verification
REQ-031 Reset then en=1: busy=1 for exactly 256 cycles; then action_valid rises NUM_ACTIONS+1 cycles later with action=0 (epsilon=0, all ties).
REQ-032 epsilon=0, start_state=5, step reward=400, obs_state=6, non-terminal -> Q(5,0)=100, step_count=1.
  - Then a step from state 6 with reward 0 and obs_state=5 -> Q(6,0)=18.
REQ-033 Terminal: reward=-800, obs_terminal=1 from fresh state 5 -> Q(5,0)=-200; next scan is of start_state, with no SCAN_NXT.
REQ-034 Hold action_ready=0 for 10 cycles and toggle obs_valid -> action stable, obs_ready=0, no update.
REQ-035 Reward 32767 repeated on a self-loop for 200 steps -> Q monotonically non-decreasing and never negative (saturation).
REQ-036 epsilon=16'hFFFF with a fixed LFSR seed -> action sequence matches the reference LFSR model; en=0 for 5 cycles mid-WAIT_OBS freezes all outputs.
